// File: rtl/line_fetch_buffer.sv
// line_fetch_buffer: ping-pong line buffer filled from packed nibble memory.
// The back half is filled pixel by pixel while the display reads the front half.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no fetch in progress, address outputs hold last value
// SETUP   | address/nibble select for pixel wr_x presented to memory
// WAIT    | FETCH_WAIT cycles of memory latency, outputs held
// CAPTURE | mem_pixel written to back buffer at wr_x, wr_x advances
module line_fetch_buffer #(
    parameter int LINE_PIXELS = 160,
    parameter int ADDR_W      = 9,
    parameter int PIX_W       = 4,
    parameter int FETCH_WAIT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              bank_sel,
    input  logic [7:0]        rd_x,
    output logic [PIX_W-1:0]  rd_pixel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_bank,
    output logic [2:0]        mem_pix_sel,
    input  logic [PIX_W-1:0]  mem_pixel,
    output logic              busy,
    output logic              underrun
);

    localparam int WORDS  = LINE_PIXELS / 8;
    localparam int WAIT_W = $clog2(FETCH_WAIT + 2);

    typedef enum logic [1:0] {IDLE, SETUP, WAIT, CAPTURE} state_t;

    state_t              state;
    logic                front;
    logic [ADDR_W-1:0]   line_base;
    logic [7:0]          wr_x;
    logic [WAIT_W-1:0]   wait_cnt;

    logic [PIX_W-1:0]    buf0 [LINE_PIXELS];
    logic [PIX_W-1:0]    buf1 [LINE_PIXELS];

    logic [7:0]          wr_x_inc;
    logic [ADDR_W-1:0]   base_next;
    logic                start_evt;
    logic                wr_en;

    assign wr_x_inc  = wr_x + 8'd1;
    assign base_next = line_base + ADDR_W'(WORDS);
    assign start_evt = frame_start | line_start;
    // A start event in the capture cycle abandons the pixel rather than writing it.
    assign wr_en     = (state == CAPTURE) && !start_evt;

    // Fetch sequencer: start events override whatever the FSM is doing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            front       <= 1'b0;
            line_base   <= '0;
            wr_x        <= '0;
            wait_cnt    <= '0;
            mem_addr    <= '0;
            mem_pix_sel <= '0;
            mem_bank    <= 1'b0;
            busy        <= 1'b0;
            underrun    <= 1'b0;
        end else if (frame_start) begin
            line_base   <= '0;
            mem_bank    <= bank_sel;
            underrun    <= 1'b0;
            wr_x        <= '0;
            mem_addr    <= '0;
            mem_pix_sel <= '0;
            busy        <= 1'b1;
            state       <= SETUP;
        end else if (line_start) begin
            if (state != IDLE)
                underrun <= 1'b1;
            front       <= ~front;
            line_base   <= base_next;
            wr_x        <= '0;
            mem_addr    <= base_next;
            mem_pix_sel <= '0;
            busy        <= 1'b1;
            state       <= SETUP;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                end
                SETUP: begin
                    if (FETCH_WAIT == 0) begin
                        state <= CAPTURE;
                    end else begin
                        wait_cnt <= WAIT_W'(FETCH_WAIT - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0)
                        state <= CAPTURE;
                    else
                        wait_cnt <= wait_cnt - 1'b1;
                end
                CAPTURE: begin
                    wr_x <= wr_x_inc;
                    if (wr_x == 8'(LINE_PIXELS - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        // Present the next pixel's address on entry to SETUP.
                        mem_addr    <= line_base + ADDR_W'(wr_x_inc[7:3]);
                        mem_pix_sel <= wr_x_inc[2:0];
                        state       <= SETUP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Back-buffer write port; the line RAM itself carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (front)
                buf0[wr_x] <= mem_pixel;
            else
                buf1[wr_x] <= mem_pixel;
        end
    end

    // Display read port from the front buffer, zero beyond the visible line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_pixel <= '0;
        else if ({1'b0, rd_x} < 9'(LINE_PIXELS))
            rd_pixel <= front ? buf1[rd_x] : buf0[rd_x];
        else
            rd_pixel <= '0;
    end

endmodule

// File: tb/tb_line_fetch_buffer.sv
// tb_line_fetch_buffer: directed test of the ping-pong line fetch buffer.
module tb_line_fetch_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       line_start = 1'b0;
    logic       bank_sel = 1'b0;
    logic [7:0] rd_x = 8'd0;
    logic [3:0] rd_pixel;
    logic [8:0] mem_addr;
    logic       mem_bank;
    logic [2:0] mem_pix_sel;
    logic [3:0] mem_pixel;
    logic       busy;
    logic       underrun;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] x;
        logic [3:0] pix;
    } vec_t;

    vec_t tbl [9];

    line_fetch_buffer #(
        .LINE_PIXELS(160),
        .ADDR_W     (9),
        .PIX_W      (4),
        .FETCH_WAIT (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .line_start (line_start),
        .bank_sel   (bank_sel),
        .rd_x       (rd_x),
        .rd_pixel   (rd_pixel),
        .mem_addr   (mem_addr),
        .mem_bank   (mem_bank),
        .mem_pix_sel(mem_pix_sel),
        .mem_pixel  (mem_pixel),
        .busy       (busy),
        .underrun   (underrun)
    );

    // Memory model: nibble = word address low bits xor nibble select.
    assign mem_pixel = mem_addr[3:0] ^ {1'b0, mem_pix_sel};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_line();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, output int cycles);
        cycles = 0;
        while (busy && cycles < 2000) begin
            tick();
            cycles++;
        end
        check(name, int'(busy), 0);
    endtask

    task automatic read_px(input string name, input logic [7:0] x, input int exp);
        rd_x = x;
        tick();
        check(name, int'(rd_pixel), exp);
    endtask

    initial begin
        int cyc;
        int seq_err;
        int a264;
        int a288;
        int busy_err;

        // Line 0 (base 0): pixel x -> (x/8)[3:0] ^ (x%8)
        tbl[0] = '{8'd0,   4'h0};
        tbl[1] = '{8'd7,   4'h7};
        tbl[2] = '{8'd9,   4'h0};
        tbl[3] = '{8'd10,  4'h3};
        tbl[4] = '{8'd63,  4'h0};
        tbl[5] = '{8'd64,  4'h8};
        tbl[6] = '{8'd159, 4'h4};
        tbl[7] = '{8'd160, 4'h0};
        tbl[8] = '{8'd255, 4'h0};

        // Reset state
        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_mem_bank", int'(mem_bank), 0);
        check("rst_pix_sel", int'(mem_pix_sel), 0);
        check("rst_rd_pixel", int'(rd_pixel), 0);
        reset = 1'b0;
        tick();

        // Reset in the middle of a fetch
        bank_sel = 1'b1;
        pulse_frame();
        repeat (50) tick();
        check("mid_busy", int'(busy), 1);
        #2 reset = 1'b1;
        tick();
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_underrun", int'(underrun), 0);
        check("mid_rst_mem_addr", int'(mem_addr), 0);
        check("mid_rst_mem_bank", int'(mem_bank), 0);
        check("mid_rst_pix_sel", int'(mem_pix_sel), 0);
        reset = 1'b0;
        tick();

        // Full line 0 fetch from bank 1
        pulse_frame();
        check("f0_mem_bank", int'(mem_bank), 1);
        check("f0_mem_addr", int'(mem_addr), 0);
        wait_idle("f0_idle", cyc);
        check("f0_busy_len", cyc, 480);
        check("f0_underrun", int'(underrun), 0);

        // Swap: line 0 to the front, line 1 starts at word 20
        pulse_line();
        check("l1_mem_addr", int'(mem_addr), 20);
        check("l1_busy", int'(busy), 1);
        for (int i = 0; i < 9; i++) begin
            rd_x = tbl[i].x;
            tick();
            check($sformatf("tbl_rd_x%0d", tbl[i].x), int'(rd_pixel), int'(tbl[i].pix));
        end
        wait_idle("l1_idle", cyc);
        check("l1_underrun", int'(underrun), 0);

        // Next line after a complete fetch: line 1 to the front, base 40
        pulse_line();
        check("l2_mem_addr", int'(mem_addr), 40);
        check("l2_underrun", int'(underrun), 0);
        read_px("l2_rd_x10", 8'd10, 7);
        read_px("l2_rd_x8", 8'd8, 5);

        // Line start 100 cycles later, fetch incomplete -> underrun
        repeat (97) tick();
        pulse_line();
        check("ur_underrun", int'(underrun), 1);
        check("ur_mem_addr", int'(mem_addr), 60);
        check("ur_pix_sel", int'(mem_pix_sel), 0);
        repeat (5) tick();
        check("ur_sticky", int'(underrun), 1);

        // frame_start with line_start: no swap, base 0, underrun cleared
        frame_start = 1'b1;
        line_start  = 1'b1;
        tick();
        frame_start = 1'b0;
        line_start  = 1'b0;
        check("fl_mem_addr", int'(mem_addr), 0);
        check("fl_underrun", int'(underrun), 0);
        check("fl_busy", int'(busy), 1);
        // Front still holds the partial line 2 (base 40)
        read_px("fl_rd_x0", 8'd0, 8);
        read_px("fl_rd_x10", 8'd10, 11);
        wait_idle("fl_idle", cyc);
        pulse_line();
        check("fl_l1_mem_addr", int'(mem_addr), 20);
        read_px("fl_front_x10", 8'd10, 3);

        // Walk line_base up to 500 and watch the address wrap
        bank_sel = 1'b0;
        pulse_frame();
        check("w_mem_bank", int'(mem_bank), 0);
        for (int n = 0; n < 25; n++) begin
            repeat (4) tick();
            pulse_line();
        end
        check("w_base", int'(mem_addr), 500);
        seq_err  = 0;
        busy_err = 0;
        a264     = -1;
        a288     = -1;
        for (int k = 0; k < 480; k++) begin
            if (int'(mem_addr) != ((500 + (k / 3) / 8) % 512))
                seq_err++;
            if (busy !== 1'b1)
                busy_err++;
            if (k == 264)
                a264 = int'(mem_addr);
            if (k == 288)
                a288 = int'(mem_addr);
            tick();
        end
        check("w_seq_errors", seq_err, 0);
        check("w_busy_errors", busy_err, 0);
        check("w_addr_511", a264, 511);
        check("w_addr_0", a288, 0);
        check("w_done_busy", int'(busy), 0);
        check("w_hold_addr", int'(mem_addr), 7);
        pulse_line();
        read_px("w_rd_x89", 8'd89, 14);
        read_px("w_rd_x97", 8'd97, 1);
        read_px("w_rd_x200", 8'd200, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
